// File: rtl/sseg_scan_mux.sv
//==============================================================================
// Module      : sseg_scan_mux
// Description : Time-multiplexed scan controller for a multi-digit seven-segment
//               display. Holds a double-buffered frame of 4-bit codes and dot
//               flags, lights one digit at a time with a dark gap between
//               digits, and optionally suppresses leading zeros.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sseg_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 8,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dots_in,
    input  logic                  lz_blank,
    output logic [3:0]            hex,
    output logic                  dip,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int                IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  c_show_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  c_gap_last  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(DIGITS - 1);
    localparam logic [3:0]        c_blank     = 4'hF;

    typedef enum logic [0:0] {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Scan sequencing state
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;

    // Double-buffered frame: shadow collects loads, active is what is scanned
    logic [4*DIGITS-1:0]   act_code_q, act_code_d;
    logic [DIGITS-1:0]     act_dot_q,  act_dot_d;
    logic [4*DIGITS-1:0]   sh_code_q,  sh_code_d;
    logic [DIGITS-1:0]     sh_dot_q,   sh_dot_d;
    logic                  pend_q,     pend_d;

    // Registered display outputs
    logic [3:0]            hex_q, hex_d;
    logic                  dip_q, dip_d;
    logic [DIGITS-1:0]     an_q,  an_d;
    logic                  fd_q,  fd_d;

    // Combinational helpers
    logic                  w_boundary;
    logic [4*DIGITS-1:0]   w_eff_code;
    logic                  w_blanking;

    // Prescaler and digit sequencing: SHOW -> GAP -> SHOW(next digit)
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        w_boundary = 1'b0;
        case (state_q)
            ST_SHOW: begin
                if (cnt_q == c_show_last) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == c_gap_last) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    if (idx_q == c_idx_last) begin
                        idx_d      = '0;
                        w_boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Frame buffering: a boundary promotes the pre-load shadow, while a load on
    // the same cycle lands in the shadow and keeps the pending flag raised
    always_comb begin
        sh_code_d  = sh_code_q;
        sh_dot_d   = sh_dot_q;
        act_code_d = act_code_q;
        act_dot_d  = act_dot_q;
        pend_d     = pend_q;
        if (w_boundary && pend_q) begin
            act_code_d = sh_code_q;
            act_dot_d  = sh_dot_q;
            pend_d     = 1'b0;
        end
        if (load) begin
            sh_code_d = digits_in;
            sh_dot_d  = dots_in;
            pend_d    = 1'b1;
        end
    end

    // Leading-zero suppression on the frame that will be visible next cycle;
    // walks down from the most significant digit and never touches digit 0
    always_comb begin
        w_eff_code = act_code_d;
        w_blanking = lz_blank;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (w_blanking && (act_code_d[4*k +: 4] == 4'h0) && !act_dot_d[k]) begin
                w_eff_code[4*k +: 4] = c_blank;
            end else begin
                w_blanking = 1'b0;
            end
        end
    end

    // Output selection: captured only on SHOW entry so a live lz_blank change
    // cannot alter a digit that is already lit
    always_comb begin
        an_d  = an_q;
        hex_d = hex_q;
        dip_d = dip_q;
        fd_d  = w_boundary;
        if (state_d == ST_GAP) begin
            an_d  = '0;
            hex_d = c_blank;
            dip_d = 1'b0;
        end else if (state_q == ST_GAP) begin
            an_d  = '0;
            hex_d = c_blank;
            dip_d = 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                if (idx_d == IDX_W'(k)) begin
                    an_d[k] = 1'b1;
                    hex_d   = w_eff_code[4*k +: 4];
                    dip_d   = act_dot_d[k];
                end
            end
        end
    end

    // State, frame and output registers with asynchronous reset to a dark display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_GAP;
            cnt_q      <= '0;
            idx_q      <= c_idx_last;
            act_code_q <= '1;
            act_dot_q  <= '0;
            sh_code_q  <= '1;
            sh_dot_q   <= '0;
            pend_q     <= 1'b0;
            hex_q      <= c_blank;
            dip_q      <= 1'b0;
            an_q       <= '0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_code_q <= act_code_d;
            act_dot_q  <= act_dot_d;
            sh_code_q  <= sh_code_d;
            sh_dot_q   <= sh_dot_d;
            pend_q     <= pend_d;
            hex_q      <= hex_d;
            dip_q      <= dip_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign hex        = hex_q;
    assign dip        = dip_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: doc/sseg_scan_mux.md
# sseg_scan_mux

Time-multiplexed scan controller for the multi-digit seven-segment display of the weighing scale. It holds a frame of DIGITS 4-bit display codes plus per-digit dot flags and cycles through the digits one at a time. For each digit it presents the code and dot to the downstream hex-to-segment decoder and drives a one-hot digit enable. It provides tear-free frame updates, optional leading-zero blanking and an anti-ghosting dead gap between digits.

## Interface
- DIGITS, 4, number of display digits (2..8)
- SCAN_DIV, 50000, clock cycles each digit is lit (>=1)
- GAP_CYC, 8, dead cycles with all digits off between digits (>=1)
- CNT_W, 16, prescaler counter width; must hold max(SCAN_DIV, GAP_CYC)-1
- clk  input  1  system clock; the block uses this single clock
- rst  input  1  reset, asynchronous, active-high
- load  input  1  one-cycle strobe; capture digits_in/dots_in into shadow frame
- digits_in  input  4*DIGITS  codes; digit k = bits [4k+3:4k], digit 0 rightmost; 4'hF = blank
- dots_in  input  DIGITS  dot flag per digit
- lz_blank  input  1  enable leading-zero suppression (sampled live)
- hex  output  4  code to decoder
- dip  output  1  dot to decoder
- an  output  DIGITS  digit enable, active-high, one-hot or all-zero
- frame_done  output  1  one-cycle pulse at each frame boundary

## Operation
- Registers: active frame (codes + dots), shadow frame, pending flag, digit index idx, prescaler cnt, FSM state.
- FSM states: SHOW (digit idx lit) and GAP (all dark).
  - SHOW: cnt counts 0..SCAN_DIV-1. At terminal count: go to GAP and clear cnt.
  - GAP: cnt counts 0..GAP_CYC-1. At terminal count: idx advances (DIGITS-1 wraps to 0), go to SHOW and clear cnt.
- Frame boundary: the GAP→SHOW transition with idx wrapping DIGITS-1→0.
- load: shadow <= inputs; pending <= 1. Repeated loads within one frame overwrite the shadow; the last load wins.
- At a frame boundary with pending=1: active <= shadow and pending <= 0.
- If load coincides with the boundary cycle:
  - active takes the pre-load shadow (only if pending was already set).
  - shadow takes the new inputs and pending stays 1.
  - The new value is displayed from the next boundary.
- Effective code, with lz_blank=1:
  - Scanning from digit DIGITS-1 downward, each digit whose code is 4'h0 and whose dot is 0 is replaced by 4'hF.
  - Blanking stops at the first digit that is nonzero or has its dot set.
  - Digit 0 is never blanked.
- With lz_blank=0 the codes pass through unchanged.
- Outputs are registers loaded on the same edge that enters or stays in a state:
  - SHOW: an = 1<<idx, hex = effective code[idx], dip = active dot[idx].
  - GAP: an = 0, hex = 4'hF, dip = 0.
- frame_done = 1 for exactly the one cycle following the boundary edge.

## Timing
- Reset values:
  - an=0, hex=4'hF, dip=0, frame_done=0.
  - Active and shadow frames all 4'hF with dots 0; pending=0.
  - State GAP, idx=DIGITS-1, cnt=0.
- Reset acts immediately (asynchronously) at any point, including mid-SHOW. All outputs go to their reset values and any pending load is discarded.
- After reset release: GAP_CYC dark cycles, then a boundary. The first frame shows the blank frame, or the shadow if a load occurred during those cycles.
- Digit period = SCAN_DIV + GAP_CYC cycles. Frame period = DIGITS*(SCAN_DIV+GAP_CYC).
- Load-to-display latency: at least 1 cycle; worst case one full frame period plus 1 cycle.
- an is never multi-hot. No two digits are ever lit on adjacent cycles; at least GAP_CYC dark cycles separate them.
- lz_blank changes take effect on the next SHOW entry (per-digit granularity).

## Test plan
Bench parameters for all scenarios: DIGITS=4, SCAN_DIV=4, GAP_CYC=2.
- Reset: assert rst -> an=0000, hex=F, dip=0, frame_done=0; release -> 2 dark cycles, frame_done pulse, an=0001 hex=F for 4 cycles, then 2 cycles an=0000.
- Basic scan: load digits_in=16'h1234, dots_in=4'b0100, lz_blank=0 before the first boundary -> the following sequence, each lit for 4 cycles with 2 dark cycles between, then repeating with frame_done each frame:
  - an=0001 hex=4, an=0010 hex=3, an=0100 hex=2 dip=1, an=1000 hex=1.
- Leading zeros, with lz_blank=1:
  - 16'h0050 -> digits 3..0 = F,F,5,0.
  - 16'h0000 -> F,F,F,0.
  - 16'h0005 with dots 4'b0100 -> F,0(dip=1),0,5.
  - With lz_blank=0, 16'h0050 -> 0,0,5,0.
- Mid-frame update: running 16'h1234, load 16'h9876 while idx=1, then load 16'hABCD while idx=2 -> digits 2,3 still show 2,1; next frame shows D,C,B,A; 16'h9876 never appears.
- Boundary collision: pending 16'h1111; load 16'h2222 on the boundary cycle -> the frame just starting shows 1,1,1,1; the following frame shows 2,2,2,2.
- Async reset mid-operation: assert rst during SHOW of digit 2 -> an=0000 and hex=F with no clock edge; the pending load is dropped and the display restarts blank.
